// File: rtl/coin_acceptor_if.sv
// Coin-slot signal bundle between the sensor conditioner (master) and the vending controller
// (slave). Defining COIN_AUDIT_EN adds the accepted/rejected coin counters to the bundle.
interface coin_acceptor_if;
  logic coin_sense;
  logic accept_en;
  logic coin_in;
  logic coin_reject;
  logic jam;
`ifdef COIN_AUDIT_EN
  logic [15:0] coin_count;
  logic [15:0] reject_count;

  modport master (
    input  coin_sense,
    input  accept_en,
    output coin_in,
    output coin_reject,
    output jam,
    output coin_count,
    output reject_count
  );

  modport slave (
    output coin_sense,
    output accept_en,
    input  coin_in,
    input  coin_reject,
    input  jam,
    input  coin_count,
    input  reject_count
  );
`else
  modport master (
    input  coin_sense,
    input  accept_en,
    output coin_in,
    output coin_reject,
    output jam
  );

  modport slave (
    output coin_sense,
    output accept_en,
    input  coin_in,
    input  coin_reject,
    input  jam
  );
`endif
endinterface

// File: rtl/coin_acceptor.sv
// Coin-slot conditioner: synchronise, debounce, measure dwell, classify into accept/reject pulses
// and flag jams. Optional feature macro COIN_AUDIT_EN adds saturating coin/reject counters.
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MIN_W           = 20,
  parameter int unsigned MAX_W           = 60,
  parameter int unsigned JAM_W           = 200
) (
  input logic             clk,
  input logic             rst,
  coin_acceptor_if.master bus
);

  localparam int unsigned WW = $clog2(JAM_W + 1);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StMeasure, StEval, StJam} state_e;

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  state_e        state_q, state_d;
  logic [WW-1:0] width_q, width_d;
  logic          in_range;
  logic          pulse_in, pulse_rej, jam_lvl;

  // Counter only advances on consecutive disagreement, so short glitches never reach the FSM.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        db_d = ~db_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= bus.coin_sense;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign in_range = (width_q >= WW'(MIN_W)) && (width_q <= WW'(MAX_W));

  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    pulse_in  = 1'b0;
    pulse_rej = 1'b0;
    jam_lvl   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (db_q) begin
          state_d = StMeasure;
          width_d = WW'(1);
        end
      end
      StMeasure: begin
        if (!db_q) begin
          state_d = StEval;
        end else if (width_q == WW'(JAM_W - 1)) begin
          // Width stops at JAM_W; the JAM state holds it there until the slot clears.
          width_d = WW'(JAM_W);
          state_d = StJam;
        end else begin
          width_d = width_q + 1'b1;
        end
      end
      StEval: begin
        pulse_in  = in_range && bus.accept_en;
        pulse_rej = !(in_range && bus.accept_en);
        state_d   = StIdle;
        width_d   = '0;
      end
      StJam: begin
        jam_lvl = 1'b1;
        if (!db_q) begin
          state_d = StIdle;
          width_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        width_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      width_q <= '0;
    end else begin
      state_q <= state_d;
      width_q <= width_d;
    end
  end

  assign bus.coin_in     = pulse_in;
  assign bus.coin_reject = pulse_rej;
  assign bus.jam         = jam_lvl;

`ifdef COIN_AUDIT_EN
  logic [15:0] coin_count_q, reject_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coin_count_q   <= '0;
      reject_count_q <= '0;
    end else begin
      if (pulse_in && (coin_count_q != 16'hFFFF)) begin
        coin_count_q <= coin_count_q + 16'd1;
      end
      if (pulse_rej && (reject_count_q != 16'hFFFF)) begin
        reject_count_q <= reject_count_q + 16'd1;
      end
    end
  end

  assign bus.coin_count   = coin_count_q;
  assign bus.reject_count = reject_count_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: event-level model of dwell classification plus
// directed scenarios with hand-computed pulse counts, latency and jam duration.
module tb_coin_acceptor;

  localparam int D     = 4;
  localparam int MIN_W = 20;
  localparam int MAX_W = 60;
  localparam int JAM_W = 200;

  logic clk;
  logic rst;
  coin_acceptor_if bus ();

  coin_acceptor #(
    .DEBOUNCE_CYCLES(D),
    .MIN_W          (MIN_W),
    .MAX_W          (MAX_W),
    .JAM_W          (JAM_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: edge index, delayed sensor samples, debounced level, coin timing.
  int n, run, n_r, mwidth, ewidth;
  bit ms1, ms2, mdb, in_coin, fall_pending, jammed, exp_eval;
  int m_in_cnt, m_rej_cnt;

  // DUT observation counters used by the directed checks.
  int dut_in, dut_rej, jam_cycles;

  function automatic bit model_accept();
    return exp_eval && (ewidth >= MIN_W) && (ewidth <= MAX_W) && (bus.accept_en == 1'b1);
  endfunction

  // Dwell is the edge distance between debounced rise and fall; classification appears one
  // cycle after the fall, jam once the coin has been present JAM_W edges.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      n = 0; run = 0; n_r = 0; mwidth = 0; ewidth = 0;
      ms1 = 0; ms2 = 0; mdb = 0; in_coin = 0; fall_pending = 0; jammed = 0; exp_eval = 0;
      m_in_cnt = 0; m_rej_cnt = 0;
    end else begin
      n++;
      if (exp_eval) begin
        if (model_accept()) begin
          if (m_in_cnt < 65535) m_in_cnt++;
        end else begin
          if (m_rej_cnt < 65535) m_rej_cnt++;
        end
      end
      exp_eval = 0;
      if (fall_pending) begin
        fall_pending = 0;
        if (jammed) jammed = 0;
        else begin
          exp_eval = 1;
          ewidth   = mwidth;
        end
      end
      if (ms2 != mdb) run++;
      else run = 0;
      ms2 = ms1;
      ms1 = bus.coin_sense;
      if (run == D) begin
        run = 0;
        mdb = !mdb;
        if (mdb) begin
          n_r     = n;
          in_coin = 1;
        end else begin
          in_coin      = 0;
          fall_pending = 1;
          mwidth       = n - n_r;
        end
      end
      if ((in_coin || fall_pending) && (n - n_r >= JAM_W)) jammed = 1;
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    bit e_in, e_rej;
    @(negedge clk);
    e_in  = model_accept();
    e_rej = exp_eval && !e_in;
    vectors++;
    if (bus.coin_in !== e_in || bus.coin_reject !== e_rej || bus.jam !== jammed) begin
      miscompares++;
      $display("FAIL cycle t=%0t: coin_in=%0b/%0b coin_reject=%0b/%0b jam=%0b/%0b (got/expected)",
               $time, bus.coin_in, e_in, bus.coin_reject, e_rej, bus.jam, jammed);
    end
`ifdef COIN_AUDIT_EN
    vectors++;
    if (bus.coin_count !== 16'(m_in_cnt) || bus.reject_count !== 16'(m_rej_cnt)) begin
      miscompares++;
      $display("FAIL audit t=%0t: coin_count=%0d/%0d reject_count=%0d/%0d (got/expected)",
               $time, bus.coin_count, m_in_cnt, bus.reject_count, m_rej_cnt);
    end
`endif
    if (bus.coin_in === 1'b1) dut_in++;
    if (bus.coin_reject === 1'b1) dut_rej++;
    if (bus.jam === 1'b1) jam_cycles++;
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // All stimulus steps start and end 1 time unit after a rising edge.
  task automatic hold(input bit v, input int c);
    bus.coin_sense = v;
    repeat (c) @(posedge clk);
    #1;
  endtask

  // Drop the sensor and watch 30 cycles; lat = negedge index of the first pulse, -1 if none.
  task automatic release_and_watch(output int lat);
    bus.coin_sense = 1'b0;
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (lat < 0 && (bus.coin_in === 1'b1 || bus.coin_reject === 1'b1)) lat = i;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input string name, input int h, input int exp_in, input int exp_rej);
    int b_in, b_rej, lat;
    b_in  = dut_in;
    b_rej = dut_rej;
    hold(1'b1, h);
    release_and_watch(lat);
    check({name, " coin_in pulses"}, dut_in - b_in, exp_in);
    check({name, " coin_reject pulses"}, dut_rej - b_rej, exp_rej);
  endtask

  initial begin
    int b_in, b_rej, b_jam, lat;
    rst = 1'b1;
    bus.coin_sense = 1'b0;
    bus.accept_en  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset coin_in", int'(bus.coin_in), 0);
    check("reset coin_reject", int'(bus.coin_reject), 0);
    check("reset jam", int'(bus.jam), 0);
    rst = 1'b0;
    hold(1'b0, 5);

    // 40-cycle coin: one coin_in, 2 sync + 4 debounce + 1 eval edges after the first low sample.
    b_in = dut_in;
    b_rej = dut_rej;
    hold(1'b1, 40);
    release_and_watch(lat);
    check("w40 latency", lat, 8);
    check("w40 coin_in pulses", dut_in - b_in, 1);
    check("w40 coin_reject pulses", dut_rej - b_rej, 0);

    coin("w20", 20, 1, 0);
    coin("w60", 60, 1, 0);
    coin("w19", 19, 0, 1);
    coin("w61", 61, 0, 1);
    coin("w199", 199, 0, 1);

    bus.accept_en = 1'b0;
    coin("w40 refused", 40, 0, 1);

    // accept_en only matters in the evaluation cycle.
    b_in = dut_in;
    b_rej = dut_rej;
    hold(1'b1, 20);
    bus.accept_en = 1'b1;
    hold(1'b1, 20);
    release_and_watch(lat);
    check("late accept coin_in", dut_in - b_in, 1);
    check("late accept coin_reject", dut_rej - b_rej, 0);

    // Jam: blocked 250 cycles, jam held from dwell 200 through the debounced fall.
    b_jam = jam_cycles;
    coin("w250 jam", 250, 0, 0);
    check("w250 jam cycles", jam_cycles - b_jam, 51);
    check("w250 jam cleared", int'(bus.jam), 0);
    b_jam = jam_cycles;
    coin("w200 jam", 200, 0, 0);
    check("w200 jam cycles", jam_cycles - b_jam, 1);

    // Glitch then chatter around a coin: only the 44-cycle debounced dwell is seen.
    b_in = dut_in;
    b_rej = dut_rej;
    hold(1'b1, 3);
    hold(1'b0, 12);
    check("glitch pulses", (dut_in - b_in) + (dut_rej - b_rej), 0);
    hold(1'b1, 2); hold(1'b0, 2); hold(1'b1, 2); hold(1'b0, 2);
    hold(1'b1, 40); hold(1'b0, 2); hold(1'b1, 2);
    release_and_watch(lat);
    check("chatter coin_in", dut_in - b_in, 1);
    check("chatter coin_reject", dut_rej - b_rej, 0);

    // Reset at dwell 30 drops the coin; outputs and counters clear immediately.
    b_in = dut_in;
    b_rej = dut_rej;
    hold(1'b1, 35);
    rst = 1'b1;
    bus.coin_sense = 1'b0;
    #1;
    check("mid reset coin_in", int'(bus.coin_in), 0);
    check("mid reset coin_reject", int'(bus.coin_reject), 0);
    check("mid reset jam", int'(bus.jam), 0);
`ifdef COIN_AUDIT_EN
    check("mid reset coin_count", int'(bus.coin_count), 0);
    check("mid reset reject_count", int'(bus.reject_count), 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    hold(1'b0, 30);
    check("after reset pulses", (dut_in - b_in) + (dut_rej - b_rej), 0);

    // Sensor high across reset release: measured from debounce completion, dwell 35.
    b_in = dut_in;
    b_rej = dut_rej;
    hold(1'b1, 10);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    hold(1'b1, 35);
    release_and_watch(lat);
    check("partial coin_in", dut_in - b_in, 1);
    check("partial coin_reject", dut_rej - b_rej, 0);
`ifdef COIN_AUDIT_EN
    check("partial coin_count", int'(bus.coin_count), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
